// File: rtl/systolic_pkg.sv
// systolic_pkg: shared constants, FSM states and run lengths for the systolic array feeder
// Ports: none (package).
package systolic_pkg;
    localparam int ARR_N = 4;
    localparam int ARR_K = 4;
    localparam int DATA_W = 16;
    localparam int FEED_LEN = ARR_K + ARR_N - 1;
    localparam int DRAIN_LEN = 2 * ARR_N - 1;
    localparam int MAX_NK = ARR_N > ARR_K ? ARR_N : ARR_K;
    localparam int IDX_W = MAX_NK > 1 ? $clog2(MAX_NK) : 1;
    localparam int KW = ARR_K > 1 ? $clog2(ARR_K) : 1;
    localparam int CNT_W = $clog2((FEED_LEN > DRAIN_LEN ? FEED_LEN : DRAIN_LEN) + 1);
    typedef enum logic [1:0] {IDLE, CLEAR, FEED, DRAIN} state_t;
endpackage

// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: buffer-write bus plus run control/status handshake
// Ports: none; master drives wr_*/start and reads busy/done, slave is the feeder.
interface systolic_feeder_if;
    import systolic_pkg::*;
    logic wr_en;
    logic wr_sel;
    logic [IDX_W-1:0] wr_row;
    logic [IDX_W-1:0] wr_col;
    logic [DATA_W-1:0] wr_data;
    logic start;
    logic busy;
    logic done;
    modport master(output wr_en, wr_sel, wr_row, wr_col, wr_data, start, input busy, done);
    modport slave(input wr_en, wr_sel, wr_row, wr_col, wr_data, start, output busy, done);
endinterface

// File: rtl/skew_lane.sv
// skew_lane: K-deep operand buffer for one array row/column, emits element t-LANE or 0
// Ports: clk/rst; we/widx/wdata write one element; en/t select during FEED; q registered operand.
module skew_lane import systolic_pkg::*; #(
    parameter int LANE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic              en,
    input  logic [CNT_W-1:0]  t,
    output logic [DATA_W-1:0] q
);
    logic [DATA_W-1:0] vec [ARR_K];
    logic [CNT_W-1:0] rd;
    logic hit;
    assign rd = t - CNT_W'(LANE);
    // diagonal skew: lane LANE is silent until t reaches LANE, then walks its K elements
    assign hit = en && t >= CNT_W'(LANE) && rd < CNT_W'(ARR_K);
    always_ff @(posedge clk)
        if (we) vec[widx[KW-1:0]] <= wdata;
    always_ff @(posedge clk)
        q <= rst ? '0 : hit ? vec[rd[KW-1:0]] : '0;
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers A/B and feeds the output-stationary array with diagonal skew
// Ports: clk/rst; bus (write bus, start, busy, done); arr_rst array clear pulse;
//        west_out slice i -> row i west input; north_out slice j -> column j north input.
module systolic_feeder import systolic_pkg::*; (
    input  logic                     clk,
    input  logic                     rst,
    systolic_feeder_if.slave         bus,
    output logic                     arr_rst,
    output logic [ARR_N*DATA_W-1:0]  west_out,
    output logic [ARR_N*DATA_W-1:0]  north_out
);
    state_t state, next_state;
    logic [CNT_W-1:0] t, next_t;
    logic last, wr_ok;
    assign last = t == (state == FEED ? CNT_W'(FEED_LEN - 1) : CNT_W'(DRAIN_LEN - 1));
    assign wr_ok = bus.wr_en && state == IDLE;
    always_comb begin
        next_state = state;
        next_t = '0;
        next_state = state == IDLE ? (bus.start ? CLEAR : IDLE) :
                     state == CLEAR ? FEED :
                     !last ? state :
                     state == FEED ? DRAIN : IDLE;
        next_t = (state == FEED || state == DRAIN) && !last ? t + 1'b1 : '0;
    end
    // status flags are registered from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            t <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            arr_rst <= 1'b0;
        end else begin
            state <= next_state;
            t <= next_t;
            bus.busy <= next_state != IDLE;
            bus.done <= state == DRAIN && last;
            arr_rst <= next_state == CLEAR;
        end
    end
    for (genvar i = 0; i < ARR_N; i++) begin : g_lane
        skew_lane #(.LANE(i)) u_row (
            .clk(clk), .rst(rst),
            .we(wr_ok && !bus.wr_sel && bus.wr_row == IDX_W'(i) && int'(bus.wr_col) < ARR_K),
            .widx(bus.wr_col), .wdata(bus.wr_data),
            .en(state == FEED), .t(t),
            .q(west_out[i*DATA_W +: DATA_W])
        );
        skew_lane #(.LANE(i)) u_col (
            .clk(clk), .rst(rst),
            .we(wr_ok && bus.wr_sel && bus.wr_col == IDX_W'(i) && int'(bus.wr_row) < ARR_K),
            .widx(bus.wr_row), .wdata(bus.wr_data),
            .en(state == FEED), .t(t),
            .q(north_out[i*DATA_W +: DATA_W])
        );
    end
endmodule
